// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, FSM encoding and ms prescaler helper
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_B_PRESS = 3'd1,
    ST_HOLD    = 3'd2,
    ST_B_REL   = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  // Clock cycles per 1 ms tick; never less than one so the prescaler always advances.
  function automatic int TICKS_PER_MS(input int clk_hz);
    return (clk_hz < 1000) ? 1 : (clk_hz / 1000);
  endfunction

endpackage

// File: rtl/keypad_matrix_responder_if.sv
// rtl/keypad_matrix_responder_if.sv - key press request handshake bundle
interface keypad_matrix_responder_if;

  logic       req_valid;
  logic [3:0] req_key;
  logic [7:0] req_hold_ms;
  logic       req_bounce;
  logic       ready;
  logic       done;

  modport master (
    output req_valid, req_key, req_hold_ms, req_bounce,
    input  ready, done
  );

  modport slave (
    input  req_valid, req_key, req_hold_ms, req_bounce,
    output ready, done
  );

endinterface

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - restartable 1 ms tick prescaler
module ms_tick_gen #(
  parameter int TICKS = 50_000
) (
  input  logic clk_50M,
  input  logic RSTn,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] r_cnt;

  // Count cycles within the current ms; clear restarts the ms phase from zero.
  always_ff @(posedge clk_50M or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_matrix_responder.sv
// rtl/keypad_matrix_responder.sv - emulated 4x4 keypad switch with bounce and holdoff
module keypad_matrix_responder
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int BOUNCE_TOGGLES = 6,
  parameter int BOUNCE_CYC     = 25_000,
  parameter int GAP_MS         = 20
) (
  input  logic                clk_50M,
  input  logic                RSTn,
  input  logic [KEY_ROWS-1:0] row,
  output logic [KEY_COLS-1:0] col,
  input  logic                req_valid,
  input  logic [3:0]          req_key,
  input  logic [7:0]          req_hold_ms,
  input  logic                req_bounce,
  output logic                ready,
  output logic                done,
  output logic                contact
);

  localparam int CYC_W = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BOUNCE_CYC - 1);
  localparam logic [7:0] TOG_LAST = 8'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);
  localparam logic [7:0] GAP_T    = 8'((GAP_MS < 1) ? 1 : GAP_MS);

  state_t           r_state, w_nxt_state;
  logic             r_contact, w_nxt_contact;
  logic             r_done, w_nxt_done;
  logic [3:0]       r_key, w_nxt_key;
  logic [7:0]       r_hold_ms, w_nxt_hold_ms;
  logic             r_bounce, w_nxt_bounce;
  logic [CYC_W-1:0] r_cyc, w_nxt_cyc;
  logic [7:0]       r_tog, w_nxt_tog;
  logic [7:0]       r_ms, w_nxt_ms;

  logic       w_tick, w_clear, w_ready;
  logic       w_cyc_done, w_burst_last, w_hold_done, w_gap_done;
  logic [7:0] w_hold_target;

  ms_tick_gen #(.TICKS(TICKS_PER_MS(CLK_HZ))) u_ms_tick (
    .clk_50M (clk_50M),
    .RSTn    (RSTn),
    .clear   (w_clear),
    .tick    (w_tick)
  );

  assign w_ready       = (r_state == ST_IDLE) && !r_done;
  assign w_hold_target = (r_hold_ms == 8'd0) ? 8'd1 : r_hold_ms;
  assign w_cyc_done    = (r_cyc == CYC_LAST);
  assign w_burst_last  = (r_tog >= TOG_LAST);
  assign w_hold_done   = w_tick && (({1'b0, r_ms} + 9'd1) >= {1'b0, w_hold_target});
  assign w_gap_done    = w_tick && (({1'b0, r_ms} + 9'd1) >= {1'b0, GAP_T});

  // State and datapath registers; reset drops the key instantly with no burst or holdoff.
  always_ff @(posedge clk_50M or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= ST_IDLE;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
      r_key     <= 4'd0;
      r_hold_ms <= 8'd0;
      r_bounce  <= 1'b0;
      r_cyc     <= '0;
      r_tog     <= 8'd0;
      r_ms      <= 8'd0;
    end else begin
      r_state   <= w_nxt_state;
      r_contact <= w_nxt_contact;
      r_done    <= w_nxt_done;
      r_key     <= w_nxt_key;
      r_hold_ms <= w_nxt_hold_ms;
      r_bounce  <= w_nxt_bounce;
      r_cyc     <= w_nxt_cyc;
      r_tog     <= w_nxt_tog;
      r_ms      <= w_nxt_ms;
    end
  end

  // Next-state and counter logic; all counters hold at their terminal value.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_contact = r_contact;
    w_nxt_done    = 1'b0;
    w_nxt_key     = r_key;
    w_nxt_hold_ms = r_hold_ms;
    w_nxt_bounce  = r_bounce;
    w_nxt_cyc     = w_cyc_done ? r_cyc : r_cyc + 1'b1;
    w_nxt_tog     = r_tog;
    w_nxt_ms      = (w_tick && (r_ms != 8'hFF)) ? r_ms + 8'd1 : r_ms;
    w_clear       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nxt_contact = 1'b0;
        if (req_valid && w_ready) begin
          w_nxt_key     = req_key;
          w_nxt_hold_ms = req_hold_ms;
          w_nxt_bounce  = req_bounce;
          w_nxt_cyc     = '0;
          w_nxt_tog     = 8'd0;
          w_nxt_ms      = 8'd0;
          w_nxt_contact = 1'b1;
          if (req_bounce) begin
            w_nxt_state = ST_B_PRESS;
          end else begin
            w_nxt_state = ST_HOLD;
            w_clear     = 1'b1;
          end
        end
      end
      ST_B_PRESS: begin
        if (w_cyc_done) begin
          w_nxt_cyc = '0;
          if (w_burst_last) begin
            w_nxt_contact = 1'b1;
            w_nxt_state   = ST_HOLD;
            w_nxt_ms      = 8'd0;
            w_clear       = 1'b1;
          end else begin
            w_nxt_contact = ~r_contact;
            w_nxt_tog     = r_tog + 8'd1;
          end
        end
      end
      ST_HOLD: begin
        w_nxt_contact = 1'b1;
        if (w_hold_done) begin
          w_nxt_contact = 1'b0;
          w_nxt_cyc     = '0;
          w_nxt_tog     = 8'd0;
          if (r_bounce) begin
            w_nxt_state = ST_B_REL;
          end else begin
            w_nxt_state = ST_GAP;
            w_nxt_ms    = 8'd0;
            w_clear     = 1'b1;
          end
        end
      end
      ST_B_REL: begin
        if (w_cyc_done) begin
          w_nxt_cyc = '0;
          if (w_burst_last) begin
            w_nxt_contact = 1'b0;
            w_nxt_state   = ST_GAP;
            w_nxt_ms      = 8'd0;
            w_clear       = 1'b1;
          end else begin
            w_nxt_contact = ~r_contact;
            w_nxt_tog     = r_tog + 8'd1;
          end
        end
      end
      ST_GAP: begin
        w_nxt_contact = 1'b0;
        if (w_gap_done) begin
          w_nxt_state = ST_IDLE;
          w_nxt_done  = 1'b1;
        end
      end
      default: begin
        w_nxt_state   = ST_IDLE;
        w_nxt_contact = 1'b0;
      end
    endcase
  end

  // Passive matrix: the pressed key pulls its column low only while its row is strobed.
  always_comb begin
    col = '1;
    if (r_contact && !row[r_key[3:2]]) begin
      col[r_key[1:0]] = 1'b0;
    end
  end

  assign ready   = w_ready;
  assign done    = r_done;
  assign contact = r_contact;

endmodule
